// File: rtl/judge_sched_if.sv
// Judge-stream bundle between the lane judges / score controller and judge_sched.
interface judge_sched_if #(
    parameter int LANES = 4
);
    logic                 i_clear;
    logic                 i_pause;
    logic [LANES-1:0]     i_lane_valid;
    logic [2*LANES-1:0]   i_lane_judge;
    logic [1:0]           o_judge;
    logic                 o_valid;
    logic [2:0]           o_lane;
    logic [LANES-1:0]     o_overflow;
    logic [15:0]          o_combo;
    logic [15:0]          o_max_combo;

    modport master (
        output i_clear, i_pause, i_lane_valid, i_lane_judge,
        input  o_judge, o_valid, o_lane, o_overflow, o_combo, o_max_combo
    );
    modport slave (
        input  i_clear, i_pause, i_lane_valid, i_lane_judge,
        output o_judge, o_valid, o_lane, o_overflow, o_combo, o_max_combo
    );
endinterface

// File: rtl/judge_sched.sv
// Round-robin serializer of per-lane judge events into one 2-bit stream, idle (00) after each event.
// Define JUDGE_COMBO_EN to build the combo / max-combo counters; otherwise they read 0.

// One pending event slot per lane.
module judge_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_valid,
    input  logic [1:0] i_code,
    input  logic       i_grant,
    output logic       o_pend,
    output logic [1:0] o_code,
    output logic       o_ovf
);
    logic       pend_q, pend_d;
    logic [1:0] code_q, code_d;
    logic       ovf_q, ovf_d;
    logic       capture;

    always_comb begin
        capture = i_valid && (i_code != 2'b00);
        pend_d  = pend_q;
        code_d  = code_q;
        ovf_d   = ovf_q;
        if (i_clear) begin
            pend_d = 1'b0;
            code_d = 2'b00;
            ovf_d  = 1'b0;
        end else if (i_grant) begin
            // Slot frees on this edge, so a same-edge event refills it.
            pend_d = capture;
            if (capture) code_d = i_code;
        end else if (capture) begin
            if (pend_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = 1'b1;
                code_d = i_code;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            code_q <= 2'b00;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            code_q <= code_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_pend = pend_q;
    assign o_code = code_q;
    assign o_ovf  = ovf_q;
endmodule

module judge_sched #(
    parameter int LANES      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    judge_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             gap_q, gap_d;
    logic [2:0]             rr_q, rr_d;
    logic [1:0]             judge_q, judge_d;
    logic                   valid_q, valid_d;
    logic [2:0]             lane_q, lane_d;

    logic [LANES-1:0]       pend;
    logic [LANES-1:0][1:0]  lane_code;
    logic [LANES-1:0]       gnt_vec;
    logic [7:0]             pend8;
    logic [7:0][1:0]        code8;
    logic                   found;
    logic [2:0]             gnt_lane;
    logic [3:0]             idx;
    logic                   do_grant;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        judge_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_clear (bus.i_clear),
            .i_valid (bus.i_lane_valid[g]),
            .i_code  (bus.i_lane_judge[2*g+1 -: 2]),
            .i_grant (gnt_vec[g]),
            .o_pend  (pend[g]),
            .o_code  (lane_code[g]),
            .o_ovf   (bus.o_overflow[g])
        );
    end

    // Rotating priority search starting at rr_q, widened to 8 lanes for uniform indexing.
    always_comb begin
        pend8    = 8'(pend);
        code8    = '0;
        for (int i = 0; i < LANES; i++) code8[i] = lane_code[i];
        found    = 1'b0;
        gnt_lane = 3'd0;
        idx      = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            idx = 4'({1'b0, rr_q}) + 4'(i);
            if (idx >= 4'(LANES)) idx = idx - 4'(LANES);
            if (!found && pend8[idx[2:0]]) begin
                found    = 1'b1;
                gnt_lane = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        rr_d     = rr_q;
        judge_d  = 2'b00;
        valid_d  = 1'b0;
        lane_d   = lane_q;
        do_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && !bus.i_pause) begin
                    do_grant = 1'b1;
                    state_d  = ISSUE;
                    judge_d  = code8[gnt_lane];
                    valid_d  = 1'b1;
                    lane_d   = gnt_lane;
                    rr_d     = (gnt_lane == 3'(LANES-1)) ? 3'd0 : gnt_lane + 3'd1;
                end
            end
            ISSUE: begin
                state_d = GAP;
                gap_d   = 4'd0;
            end
            GAP: begin
                if (gap_q == 4'(GAP_CYCLES-1)) state_d = IDLE;
                else                           gap_d   = gap_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
        if (bus.i_clear) begin
            state_d  = IDLE;
            gap_d    = 4'd0;
            rr_d     = 3'd0;
            judge_d  = 2'b00;
            valid_d  = 1'b0;
            lane_d   = 3'd0;
            do_grant = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) gnt_vec[i] = do_grant && (gnt_lane == 3'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= 4'd0;
            rr_q    <= 3'd0;
            judge_q <= 2'b00;
            valid_q <= 1'b0;
            lane_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            judge_q <= judge_d;
            valid_q <= valid_d;
            lane_q  <= lane_d;
        end
    end

    assign bus.o_judge = judge_q;
    assign bus.o_valid = valid_q;
    assign bus.o_lane  = lane_q;

`ifdef JUDGE_COMBO_EN
    logic [15:0] combo_q, combo_d;
    logic [15:0] max_q, max_d;

    always_comb begin
        combo_d = combo_q;
        max_d   = max_q;
        if (bus.i_clear) begin
            combo_d = 16'd0;
            max_d   = 16'd0;
        end else if (do_grant) begin
            // Hits (11/10) extend the combo; a Miss (01) breaks it.
            if (judge_d[1]) combo_d = (combo_q == 16'hFFFF) ? combo_q : combo_q + 16'd1;
            else            combo_d = 16'd0;
            if (combo_d > max_q) max_d = combo_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            combo_q <= 16'd0;
            max_q   <= 16'd0;
        end else begin
            combo_q <= combo_d;
            max_q   <= max_d;
        end
    end

    assign bus.o_combo     = combo_q;
    assign bus.o_max_combo = max_q;
`else
    assign bus.o_combo     = 16'd0;
    assign bus.o_max_combo = 16'd0;
`endif
endmodule

// File: doc/judge_sched.md
# judge_sched

Round-robin scheduler that serializes per-lane judge events from the note-judging lanes into the single 2-bit judge stream consumed by the score controller. The score controller scores on a change of its judge input, so this block returns the stream to idle (00) after every issued event. That makes two identical consecutive judgements, for example two Perfects, each score once. The block also holds one pending event per lane, flags lane overflow, and optionally tracks the current and maximum combo.

## Interface
Parameters:
- LANES, 4: number of judge lanes (2..8).
- GAP_CYCLES, 1: idle (00) cycles forced after each issued event (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_clear  in  1  synchronous song restart; same effect as reset on all state.
- i_pause  in  1  blocks new issues while high.
- i_lane_valid  in  LANES  one-cycle event strobe per lane.
- i_lane_judge  in  2*LANES  judge code for lane k in bits [2k+1:2k]; 11 Perfect, 10 Normal, 01 Miss, 00 none.
- o_judge  out  2  serialized judge code to the score controller; 00 when idle.
- o_valid  out  1  high for exactly the one cycle o_judge holds an event.
- o_lane  out  3  index of the lane being issued; valid only when o_valid is high.
- o_overflow  out  LANES  sticky per-lane drop flag.
- o_combo  out  16  current combo count.
- o_max_combo  out  16  highest combo reached since reset or clear.

## Operation
- Per-lane pending register holding a 2-bit code plus a pending bit.
- Capture of an event on lane k:
  - When i_lane_valid[k]=1 and the code is nonzero, the code is captured into lane k's pending register.
  - A code of 00 with the strobe high is ignored.
- Collision on lane k:
  - Lane k is already pending and is not being granted on this edge: the new event is dropped, the older one is kept, and o_overflow[k] is set.
  - Lane k is being granted on this same edge: the new event is captured and pending stays set. No overflow is flagged.
- FSM states and transitions:
  - IDLE: when any lane is pending and i_pause=0, grant the next pending lane, go to ISSUE.
  - ISSUE: one cycle, then go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Granting:
  - Priority search starts at rr_ptr and wraps modulo LANES.
  - On a grant, rr_ptr is set to (granted lane + 1) mod LANES.
  - The grant clears that lane's pending bit.
  - The grant loads o_judge with the lane's code, o_lane with its index, and o_valid=1.
- ISSUE and GAP drive o_judge=00, o_valid=0 (the granted code and o_valid=1 appear only for the single ISSUE cycle).
- i_pause is sampled only in IDLE. An ISSUE or GAP already in progress completes, and capture into pending continues while paused.
- Combo, updated on each grant:
  - A code of 11 or 10 increments o_combo; it saturates at 0xFFFF.
  - A code of 01 zeroes o_combo.
  - o_max_combo takes max(o_max_combo, new combo) in the same cycle.
- i_clear: returns the FSM to IDLE and zeroes pending, overflow, rr_ptr, combo, max combo and all outputs. i_clear has priority over same-cycle captures.

## Timing
- Reset values: o_judge=00, o_valid=0, o_lane=0, o_overflow=0, o_combo=0, o_max_combo=0, FSM=IDLE, rr_ptr=0, all pending bits clear.
- Latency: a strobe sampled at edge E, with the FSM in IDLE and not paused, produces o_valid=1 after edge E+1. o_judge returns to 00 after edge E+2.
- Minimum spacing between issued events is 2+GAP_CYCLES cycles. With GAP_CYCLES=1 that is 3 cycles, so o_judge always contains at least one 00 cycle between events.
- o_combo and o_max_combo update on the same edge that asserts o_valid.
- Reset asserted mid-ISSUE or mid-GAP forces all outputs to their reset values immediately; asynchronous assertion, synchronous release.

## Configuration
- JUDGE_COMBO_EN
  - Defined: the combo and max-combo counters are built as described in Operation.
  - Undefined: no counter logic is generated; o_combo and o_max_combo are tied to 0.
  - Scheduling, overflow and output timing are identical in both builds.

## Test plan
- Single event: lane 2 strobe with code 11 at edge E -> o_valid=1, o_judge=11, o_lane=2 after E+1; o_judge=00 after E+2; o_combo=1.
- Repeated Perfects: lane 0 strobed with code 11 at 3-cycle spacing, 3 times -> three separate o_valid pulses, each followed by a 00 cycle; o_combo=3, o_max_combo=3.
- Round-robin: all 4 lanes strobed in the same cycle with codes 11, 10, 01, 11 and rr_ptr=0 -> lanes issued in order 0, 1, 2, 3, 3 cycles apart; combo goes 1, 2, 0, 1; o_max_combo=2.
- Overflow: pause high, lane 1 strobed with code 10 then code 11 -> o_overflow[1]=1; after pause releases, exactly one event (code 10) is issued.
- Grant-edge collision: lane 3 strobed with code 01 on the edge where lane 3 is granted -> no overflow flagged; the second event issues 3 cycles later.
- Reset mid-GAP and i_clear with pending lanes -> all outputs 0 immediately (reset) or after one edge (clear); no stale event is issued afterwards.
